// File: rtl/hazard_ctrl.sv
// hazard_ctrl: control-side hazard unit for a five-stage MIPS pipeline.
// Holds the E/M/W control pipeline bits (RegWrite, MemToReg, MemWrite) and
// derives stall, flush, branch-resolve and forwarding selects from them and
// from the register indices exported by the datapath.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush/forward
// event counters (stall_cnt, flush_cnt, fwd_cnt).
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] fwd_cnt,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             BranchEqD,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             FlushD,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             PCSrcD,
  output logic             MemWriteM,
  output logic             MemToRegW,
  output logic             RegWriteW
);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Control pipeline state
  logic reg_write_e_r, mem_to_reg_e_r, mem_write_e_r;
  logic reg_write_m_r, mem_to_reg_m_r, mem_write_m_r;
  logic reg_write_w_r, mem_to_reg_w_r;

  // Hazard terms
  logic lw_stall_s;
  logic branch_stall_s;
  logic stall_s;
  logic pc_src_s;

  // Control pipeline: D->E (bubble on stall), E->M, M->W; reset drops all in-flight control.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_write_e_r  <= 1'b0;
      mem_to_reg_e_r <= 1'b0;
      mem_write_e_r  <= 1'b0;
      reg_write_m_r  <= 1'b0;
      mem_to_reg_m_r <= 1'b0;
      mem_write_m_r  <= 1'b0;
      reg_write_w_r  <= 1'b0;
      mem_to_reg_w_r <= 1'b0;
    end else begin
      if (stall_s) begin
        reg_write_e_r  <= 1'b0;
        mem_to_reg_e_r <= 1'b0;
        mem_write_e_r  <= 1'b0;
      end else begin
        reg_write_e_r  <= RegWriteD;
        mem_to_reg_e_r <= MemToRegD;
        mem_write_e_r  <= MemWriteD;
      end
      reg_write_m_r  <= reg_write_e_r;
      mem_to_reg_m_r <= mem_to_reg_e_r;
      mem_write_m_r  <= mem_write_e_r;
      reg_write_w_r  <= reg_write_m_r;
      mem_to_reg_w_r <= mem_to_reg_m_r;
    end
  end

  // Execute-stage forwarding: M stage wins over W; r0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if ((RsE != REG_ZERO) && reg_write_m_r && (RsE == WriteRegM)) begin
      ForwardAE = 2'b10;
    end else if ((RsE != REG_ZERO) && reg_write_w_r && (RsE == WriteRegW)) begin
      ForwardAE = 2'b01;
    end else begin
      ForwardAE = 2'b00;
    end
    if ((RtE != REG_ZERO) && reg_write_m_r && (RtE == WriteRegM)) begin
      ForwardBE = 2'b10;
    end else if ((RtE != REG_ZERO) && reg_write_w_r && (RtE == WriteRegW)) begin
      ForwardBE = 2'b01;
    end else begin
      ForwardBE = 2'b00;
    end
  end

  // Decode-stage hazards: load-use and branch-operand stalls, branch resolve and redirect flush.
  always_comb begin
    ForwardAD      = (RsD != REG_ZERO) && reg_write_m_r && (RsD == WriteRegM);
    ForwardBD      = (RtD != REG_ZERO) && reg_write_m_r && (RtD == WriteRegM);
    lw_stall_s     = mem_to_reg_e_r && ((RtE == RsD) || (RtE == RtD));
    branch_stall_s = BranchD &&
                     ((reg_write_e_r  && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                      (mem_to_reg_m_r && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    stall_s        = lw_stall_s || branch_stall_s;
    pc_src_s       = BranchD && BranchEqD && !stall_s;
    FlushD         = (pc_src_s || JumpD) && !stall_s;
  end

  assign StallF    = stall_s;
  assign StallD    = stall_s;
  assign FlushE    = stall_s;
  assign PCSrcD    = pc_src_s;
  assign MemWriteM = mem_write_m_r;
  assign MemToRegW = mem_to_reg_w_r;
  assign RegWriteW = reg_write_w_r;

`ifdef HAZARD_PERF_CNT_EN
  logic fwd_any_s;
  assign fwd_any_s = (ForwardAE != 2'b00) || (ForwardBE != 2'b00);

  // Event counters: one increment per cycle the event is active, saturating.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (stall_s) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (FlushD) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
      if (fwd_any_s) begin
        fwd_cnt <= sat_inc(fwd_cnt);
      end
    end
  end
`else
  // Counters not built; functional outputs are unaffected.
`endif

endmodule
